// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, clocks out one byte and checks the ACK.
// Optional PS2_TX_FILTER_EN adds a stability filter on the synchronised PS2_CLK.
module ps2_tx #(
  parameter int INHIBIT_CYC = 6000,
  parameter int TIMEOUT_CYC = 750000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
`ifdef PS2_TX_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ_SETUP, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state_reg;
  logic [1:0]    clk_sync_reg;
  logic [1:0]    dat_sync_reg;
  logic          clk_level;
  logic          clk_prev_reg;
  logic          clk_fall;
  logic [9:0]    shift_reg;
  logic [3:0]    bitcnt_reg;
  logic [IW-1:0] inh_cnt_reg;
  logic [TW-1:0] to_cnt_reg;
  logic          nack_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          error_reg;
  logic          clk_oe_reg;
  logic          dat_oe_reg;
  logic          timing;

  // Synchronisers idle high so the bus does not look like a falling edge after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_reg <= 2'b11;
      dat_sync_reg <= 2'b11;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[0], ps2_clk_i};
      dat_sync_reg <= {dat_sync_reg[0], ps2_dat_i};
      clk_prev_reg <= clk_level;
    end
  end

  if (FILTER_ON && FILTER_LEN > 1) begin : g_filt
    localparam int FW = $clog2(FILTER_LEN);
    logic          clk_filt_reg;
    logic [FW-1:0] filt_cnt_reg;

    // Level follows the synced clock only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clock) begin
      if (reset) begin
        clk_filt_reg <= 1'b1;
        filt_cnt_reg <= '0;
      end else if (clk_sync_reg[1] == clk_filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        clk_filt_reg <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
    assign clk_level = clk_filt_reg;
  end else begin : g_raw
    assign clk_level = clk_sync_reg[1];
  end

  assign clk_fall = clk_prev_reg & ~clk_level;
  assign timing   = (state_reg == S_REQ) || (state_reg == S_DATA) ||
                    (state_reg == S_ACK) || (state_reg == S_WAIT_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      bitcnt_reg  <= '0;
      inh_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      nack_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
      clk_oe_reg  <= 1'b0;
      dat_oe_reg  <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (tx_start) begin
            shift_reg   <= {1'b1, ~^tx_data, tx_data};
            bitcnt_reg  <= '0;
            inh_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            clk_oe_reg  <= 1'b1;
            state_reg   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt_reg == IW'(INHIBIT_CYC - 1)) begin
            dat_oe_reg <= 1'b1;
            state_reg  <= S_REQ_SETUP;
          end else begin
            inh_cnt_reg <= inh_cnt_reg + 1'b1;
          end
        end
        S_REQ_SETUP: begin
          clk_oe_reg <= 1'b0;
          to_cnt_reg <= '0;
          state_reg  <= S_REQ;
        end
        S_REQ, S_DATA: begin
          // Ten edges shift out data, parity and stop; the stop slot releases the line
          if (clk_fall) begin
            dat_oe_reg <= ~shift_reg[0];
            shift_reg  <= {1'b1, shift_reg[9:1]};
            bitcnt_reg <= bitcnt_reg + 1'b1;
            state_reg  <= (bitcnt_reg == 4'd9) ? S_ACK : S_DATA;
          end
        end
        S_ACK: begin
          if (clk_fall) begin
            nack_reg  <= dat_sync_reg[1];
            state_reg <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_sync_reg[1] && dat_sync_reg[1]) begin
            done_reg  <= ~nack_reg;
            error_reg <= nack_reg;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase

      // Placed after the case so an expiring timeout overrides any action above
      if (timing) begin
        if (clk_fall) begin
          to_cnt_reg <= '0;
        end else if (to_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
          clk_oe_reg <= 1'b0;
          dat_oe_reg <= 1'b0;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b0;
          error_reg  <= 1'b1;
          state_reg  <= S_IDLE;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign rx_inhibit = busy_reg;
  assign ps2_clk_oe = clk_oe_reg;
  assign ps2_dat_oe = dat_oe_reg;

endmodule
